// File: rtl/ysyx_25040129_ifu_if.sv
// Fetch-side bundle of the ysyx_25040129 IFU.
// Groups the branch redirect, the instruction-memory request/response channels and the
// decode hand-off channel.
//   master : the IFU (drives imem requests, response ready and the decode channel)
//   slave  : the environment (branch resolution, instruction memory, decode)
interface ysyx_25040129_ifu_if;
   logic        redirect_valid;
   logic [31:0] redirect_target;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;

   logic        imem_rsp_valid;
   logic        imem_rsp_ready;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;

   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_fault;

   modport master (
      input  redirect_valid, redirect_target,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
      input  inst_ready,
      output imem_req_valid, imem_req_addr, imem_rsp_ready,
      output inst_valid, inst, inst_pc, inst_fault
   );

   modport slave (
      output redirect_valid, redirect_target,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
      output inst_ready,
      input  imem_req_valid, imem_req_addr, imem_rsp_ready,
      input  inst_valid, inst, inst_pc, inst_fault
   );
endinterface

// File: rtl/ysyx_25040129_ifu.sv
// Instruction fetch unit of the ysyx_25040129 multi-cycle NPC core.
// Owns the fetch PC, keeps at most one word-aligned fetch in flight on the instruction-memory
// port and hands each fetched word plus its PC to decode. A branch redirect replaces the PC
// and squashes wrong-path work already in flight.
// Ports:
//   clock    : sole clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : ysyx_25040129_ifu_if.master (redirect, imem req/rsp, decode hand-off)
module ysyx_25040129_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input logic                 clock,
   input logic                 reset_n,
   ysyx_25040129_ifu_if.master bus
);

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StWait,
      StHold
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic        discard_q, discard_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        inst_fault_q, inst_fault_d;

   logic misaligned;
   assign misaligned = |req_addr_q[1:0];

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_addr_d   = req_addr_q;
      discard_d    = discard_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_fault_d = inst_fault_q;

      unique case (state_q)
         StIdle: begin
            state_d    = StFetch;
            // A redirect here also lands in pc_d below; steer the first fetch to it directly.
            req_addr_d = bus.redirect_valid ? bus.redirect_target : pc_q;
         end

         StFetch: begin
            if (misaligned) begin
               // Nothing is in flight, so a redirect simply retargets the pending fetch.
               if (bus.redirect_valid) begin
                  req_addr_d = bus.redirect_target;
               end else begin
                  state_d      = StHold;
                  inst_d       = 32'h0;
                  inst_pc_d    = req_addr_q;
                  inst_fault_d = 1'b1;
               end
            end else begin
               if (bus.imem_req_ready) begin
                  state_d = StWait;
                  // With discard pending, pc already holds the redirect target.
                  if (!discard_q) begin
                     pc_d = req_addr_q + 32'd4;
                  end
               end
               // The request must still complete; its response is dropped later.
               if (bus.redirect_valid) begin
                  discard_d = 1'b1;
               end
            end
         end

         StWait: begin
            if (bus.imem_rsp_valid) begin
               if (discard_q || bus.redirect_valid) begin
                  state_d    = StFetch;
                  discard_d  = 1'b0;
                  req_addr_d = bus.redirect_valid ? bus.redirect_target : pc_q;
               end else begin
                  state_d      = StHold;
                  inst_pc_d    = req_addr_q;
                  inst_fault_d = bus.imem_rsp_err;
                  inst_d       = bus.imem_rsp_err ? 32'h0 : bus.imem_rsp_data;
               end
            end else if (bus.redirect_valid) begin
               discard_d = 1'b1;
            end
         end

         StHold: begin
            // A redirect squashes the held instruction even if decode takes it this cycle.
            if (bus.redirect_valid) begin
               state_d    = StFetch;
               req_addr_d = bus.redirect_target;
            end else if (bus.inst_ready) begin
               state_d    = StFetch;
               req_addr_d = pc_q;
            end
         end

         default: state_d = StIdle;
      endcase

      if (bus.redirect_valid) begin
         pc_d = bus.redirect_target;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         req_addr_q   <= 32'h0;
         discard_q    <= 1'b0;
         inst_q       <= 32'h0;
         inst_pc_q    <= 32'h0;
         inst_fault_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_addr_q   <= req_addr_d;
         discard_q    <= discard_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_fault_q <= inst_fault_d;
      end
   end

   assign bus.imem_req_valid = (state_q == StFetch) && !misaligned;
   assign bus.imem_req_addr  = req_addr_q;
   assign bus.imem_rsp_ready = (state_q == StWait);
   assign bus.inst_valid     = (state_q == StHold);
   assign bus.inst           = inst_q;
   assign bus.inst_pc        = inst_pc_q;
   assign bus.inst_fault     = inst_fault_q;

endmodule

// File: tb/tb_ysyx_25040129_ifu.sv
module tb_ysyx_25040129_ifu;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] XOR_KEY  = 32'hA5A5_0000;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   ysyx_25040129_ifu_if bus ();
   ysyx_25040129_ifu #(.RESET_PC(RESET_PC)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Environment knobs and state
   bit          rnd;
   bit          err_en;
   int          req_delay, rsp_delay, dec_delay;
   int          rq_cnt, rs_cnt, dc_cnt;
   bit          mem_busy;
   logic [31:0] mem_addr;
   int          redir_mode;  // 0 none, 1 once in WAIT, 2 once in HOLD, 3 random
   int          redir_pct;
   logic [31:0] redir_tgt;

   // Reference model: the next instruction decode must see, and delivery bookkeeping
   logic [31:0] exp_pc;
   int          deliv_cnt;
   int          deliv_cyc[$];
   int          accepts;
   int          acc_at_redir;

   bit          prev_req_stall;
   logic [31:0] prev_req_addr;
   bit          prev_hold_stall;
   logic [31:0] prev_inst, prev_inst_pc;
   logic        prev_fault;

   bit          watch_next, watch_req, watch_lat1;
   logic [31:0] watch_addr;
   int          redir_cyc;

   typedef struct {
      bit          rv;
      logic [31:0] rt;
      bit          req_rdy;
      bit          rsp_v;
      logic [31:0] rsp_d;
      bit          rsp_e;
      bit          inst_rdy;
      bit          e_req_v;
      logic [31:0] e_req_a;
      bit          e_rsp_r;
      bit          e_inst_v;
      logic [31:0] e_inst;
      logic [31:0] e_pc;
      bit          e_fault;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int pick(input int d);
      return rnd ? int'($urandom_range(0, d)) : d;
   endfunction

   function automatic bit err_addr(input logic [31:0] a);
      return (a == 32'h8000_0010) || (err_en && a[6:2] == 5'h17);
   endfunction

   task automatic drive();
      logic [31:0] t;
      if (bus.imem_req_valid && !mem_busy) begin
         if (rq_cnt == 0) begin
            bus.imem_req_ready = 1'b1;
         end else begin
            bus.imem_req_ready = 1'b0;
            rq_cnt--;
         end
      end else begin
         bus.imem_req_ready = !mem_busy;
      end

      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
      bus.imem_rsp_err   = 1'($urandom_range(0, 1));
      if (mem_busy) begin
         if (rs_cnt == 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_addr ^ XOR_KEY;
            bus.imem_rsp_err   = err_addr(mem_addr);
         end else begin
            rs_cnt--;
         end
      end

      if (bus.inst_valid) begin
         if (dc_cnt == 0) begin
            bus.inst_ready = 1'b1;
         end else begin
            bus.inst_ready = 1'b0;
            dc_cnt--;
         end
      end else begin
         bus.inst_ready = 1'($urandom_range(0, 1));
      end

      bus.redirect_valid  = 1'b0;
      bus.redirect_target = $urandom;
      case (redir_mode)
         1: if (bus.imem_rsp_ready) begin
            bus.redirect_valid  = 1'b1;
            bus.redirect_target = redir_tgt;
            redir_mode          = 0;
         end
         2: if (bus.inst_valid) begin
            bus.inst_ready      = 1'b1;
            bus.redirect_valid  = 1'b1;
            bus.redirect_target = redir_tgt;
            redir_mode          = 0;
         end
         3: if ($urandom_range(0, 99) < redir_pct) begin
            t = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
            if ($urandom_range(0, 9) == 0) t[1:0] = 2'($urandom_range(1, 3));
            bus.redirect_valid  = 1'b1;
            bus.redirect_target = t;
         end
         default: ;
      endcase
   endtask

   task automatic sample();
      bit          redir, req_fire, rsp_fire, inst_fire, f;
      logic [31:0] exp_inst;
      redir     = bus.redirect_valid;
      req_fire  = bus.imem_req_valid && bus.imem_req_ready;
      rsp_fire  = bus.imem_rsp_valid && bus.imem_rsp_ready;
      inst_fire = bus.inst_valid && bus.inst_ready;

      if (bus.imem_req_valid) check("req_aligned", 32'(bus.imem_req_addr[1:0]), 32'd0);
      if (prev_req_stall) begin
         check("req_hold_valid", 32'(bus.imem_req_valid), 32'd1);
         check("req_hold_addr", bus.imem_req_addr, prev_req_addr);
      end
      if (prev_hold_stall) begin
         check("hold_valid", 32'(bus.inst_valid), 32'd1);
         check("hold_inst", bus.inst, prev_inst);
         check("hold_pc", bus.inst_pc, prev_inst_pc);
         check("hold_fault", 32'(bus.inst_fault), 32'(prev_fault));
      end
      if (watch_req && bus.imem_req_valid) begin
         check("redirect_req_addr", bus.imem_req_addr, watch_addr);
         if (watch_lat1) check("redirect_latency", 32'(cyc - redir_cyc), 32'd1);
         watch_req = 1'b0;
      end

      if (inst_fire && !redir) begin
         f        = (exp_pc[1:0] != 2'b00) || err_addr(exp_pc);
         exp_inst = f ? 32'h0 : (exp_pc ^ XOR_KEY);
         check("deliver_pc", bus.inst_pc, exp_pc);
         check("deliver_fault", 32'(bus.inst_fault), 32'(f));
         check("deliver_inst", bus.inst, exp_inst);
         deliv_cnt++;
         deliv_cyc.push_back(cyc);
         if (exp_pc[1:0] == 2'b00) exp_pc = exp_pc + 32'd4;
      end

      if (req_fire) begin
         mem_busy = 1'b1;
         mem_addr = bus.imem_req_addr;
         rs_cnt   = pick(rsp_delay);
         rq_cnt   = pick(req_delay);
         accepts++;
      end
      if (rsp_fire) mem_busy = 1'b0;
      if (inst_fire || (redir && bus.inst_valid)) dc_cnt = pick(dec_delay);

      if (redir) begin
         exp_pc       = bus.redirect_target;
         redir_cyc    = cyc;
         acc_at_redir = accepts;
         if (watch_next) begin
            watch_req  = 1'b1;
            watch_addr = bus.redirect_target;
            watch_next = 1'b0;
         end
      end

      prev_req_stall  = bus.imem_req_valid && !bus.imem_req_ready;
      prev_req_addr   = bus.imem_req_addr;
      prev_hold_stall = bus.inst_valid && !bus.inst_ready && !redir;
      prev_inst       = bus.inst;
      prev_inst_pc    = bus.inst_pc;
      prev_fault      = bus.inst_fault;
   endtask

   // Entered and left at 1 time unit after a rising edge.
   task automatic cycle();
      drive();
      #4;
      sample();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic run(input int n, input int budget);
      int target;
      int spent;
      target = deliv_cnt + n;
      spent  = 0;
      while (deliv_cnt < target && spent < budget) begin
         cycle();
         spent++;
      end
      check("run_delivered", 32'(deliv_cnt), 32'(target));
   endtask

   task automatic do_reset();
      reset_n             = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_target = 32'h0;
      bus.imem_req_ready  = 1'b0;
      bus.imem_rsp_valid  = 1'b0;
      bus.imem_rsp_data   = 32'h0;
      bus.imem_rsp_err    = 1'b0;
      bus.inst_ready      = 1'b0;
      mem_busy            = 1'b0;
      prev_req_stall      = 1'b0;
      prev_hold_stall     = 1'b0;
      watch_next          = 1'b0;
      watch_req           = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("rst_rsp_ready", 32'(bus.imem_rsp_ready), 32'd0);
      check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_inst", bus.inst, 32'd0);
      check("rst_inst_pc", bus.inst_pc, 32'd0);
      check("rst_inst_fault", 32'(bus.inst_fault), 32'd0);
      rq_cnt    = pick(req_delay);
      rs_cnt    = 0;
      dc_cnt    = pick(dec_delay);
      exp_pc    = RESET_PC;
      deliv_cnt = 0;
      deliv_cyc.delete();
      accepts   = 0;
      cyc       = 0;
      reset_n   = 1'b1;
   endtask

   task automatic set_env(input bit r, input int rq, input int rs, input int dc);
      rnd       = r;
      req_delay = rq;
      rsp_delay = rs;
      dec_delay = dc;
   endtask

   initial begin
      // rv rt  req_rdy rsp_v rsp_d rsp_e inst_rdy | req_v req_a rsp_r inst_v inst pc fault
      vecs.push_back('{0, 32'h0, 1, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0});
      vecs.push_back('{0, 32'h0, 1, 0, 32'h0, 0, 1, 1, 32'h8000_0000, 0, 0, 32'h0, 32'h0, 0});
      vecs.push_back('{0, 32'h0, 0, 1, 32'h2525_0000, 0, 1, 0, 32'h0, 1, 0, 32'h0, 32'h0, 0});
      vecs.push_back('{0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 32'h2525_0000,
                       32'h8000_0000, 0});
      vecs.push_back('{0, 32'h0, 0, 0, 32'h0, 0, 1, 1, 32'h8000_0004, 0, 0, 32'h0, 32'h0, 0});
      vecs.push_back('{0, 32'h0, 1, 0, 32'h0, 0, 1, 1, 32'h8000_0004, 0, 0, 32'h0, 32'h0, 0});
      vecs.push_back('{0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 1, 0, 32'h0, 32'h0, 0});
      vecs.push_back('{0, 32'h0, 0, 1, 32'hDEAD_BEEF, 1, 1, 0, 32'h0, 1, 0, 32'h0, 32'h0, 0});
      vecs.push_back('{0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 1, 32'h0, 32'h8000_0004, 1});
      vecs.push_back('{1, 32'h8000_0102, 0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 32'h0,
                       32'h8000_0004, 1});
      vecs.push_back('{0, 32'h0, 1, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0});
      vecs.push_back('{1, 32'h8000_0020, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 1, 32'h0,
                       32'h8000_0102, 1});
      vecs.push_back('{1, 32'h8000_0040, 0, 0, 32'h0, 0, 1, 1, 32'h8000_0020, 0, 0, 32'h0,
                       32'h0, 0});
      vecs.push_back('{0, 32'h0, 1, 0, 32'h0, 0, 1, 1, 32'h8000_0020, 0, 0, 32'h0, 32'h0, 0});
      vecs.push_back('{0, 32'h0, 0, 1, 32'h2525_0020, 0, 1, 0, 32'h0, 1, 0, 32'h0, 32'h0, 0});
      vecs.push_back('{0, 32'h0, 1, 0, 32'h0, 0, 1, 1, 32'h8000_0040, 0, 0, 32'h0, 32'h0, 0});
      vecs.push_back('{0, 32'h0, 0, 1, 32'h2525_0040, 0, 1, 0, 32'h0, 1, 0, 32'h0, 32'h0, 0});
      vecs.push_back('{0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 32'h2525_0040,
                       32'h8000_0040, 0});
      vecs.push_back('{0, 32'h0, 0, 0, 32'h0, 0, 1, 1, 32'h8000_0044, 0, 0, 32'h0, 32'h0, 0});

      err_en     = 1'b0;
      redir_mode = 0;
      redir_pct  = 0;
      redir_tgt  = 32'h0;

      // Cycle-exact vectors, row 0 is the IDLE cycle right after reset release.
      set_env(0, 0, 0, 0);
      do_reset();
      foreach (vecs[i]) begin
         bus.redirect_valid  = vecs[i].rv;
         bus.redirect_target = vecs[i].rt;
         bus.imem_req_ready  = vecs[i].req_rdy;
         bus.imem_rsp_valid  = vecs[i].rsp_v;
         bus.imem_rsp_data   = vecs[i].rsp_d;
         bus.imem_rsp_err    = vecs[i].rsp_e;
         bus.inst_ready      = vecs[i].inst_rdy;
         #4;
         check($sformatf("vec%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(vecs[i].e_req_v));
         check($sformatf("vec%0d_rsp_ready", i), 32'(bus.imem_rsp_ready), 32'(vecs[i].e_rsp_r));
         check($sformatf("vec%0d_inst_valid", i), 32'(bus.inst_valid), 32'(vecs[i].e_inst_v));
         if (vecs[i].e_req_v) begin
            check($sformatf("vec%0d_req_addr", i), bus.imem_req_addr, vecs[i].e_req_a);
         end
         if (vecs[i].e_inst_v) begin
            check($sformatf("vec%0d_inst", i), bus.inst, vecs[i].e_inst);
            check($sformatf("vec%0d_inst_pc", i), bus.inst_pc, vecs[i].e_pc);
            check($sformatf("vec%0d_inst_fault", i), 32'(bus.inst_fault), 32'(vecs[i].e_fault));
         end
         @(posedge clock);
         #1;
      end

      // Zero-wait stream from reset: one instruction per 3 cycles, fault at 8000_0010.
      set_env(0, 0, 0, 0);
      do_reset();
      run(6, 60);
      foreach (deliv_cyc[i]) begin
         if (i < 6) check($sformatf("stream_cycle%0d", i), 32'(deliv_cyc[i]), 32'(3 * (i + 1)));
      end

      // Backpressure on every channel: 15 cycles per instruction.
      set_env(0, 4, 3, 5);
      do_reset();
      run(3, 100);
      check("bp_first_cycle", 32'(deliv_cyc.size() > 0 ? deliv_cyc[0] : -1), 32'd15);
      check("bp_third_cycle", 32'(deliv_cyc.size() > 2 ? deliv_cyc[2] : -1), 32'd45);

      // Redirect in WAIT before the response: old response consumed, never delivered.
      set_env(0, 0, 2, 0);
      do_reset();
      run(1, 40);
      redir_mode = 1;
      redir_tgt  = 32'h8000_0100;
      watch_next = 1'b1;
      watch_lat1 = 1'b0;
      run(2, 60);
      check("wait_redirect_seen", 32'(watch_req || watch_next), 32'd0);

      // Redirect in HOLD with a same-cycle handshake.
      set_env(0, 0, 0, 0);
      redir_mode = 2;
      redir_tgt  = 32'h8000_0200;
      watch_next = 1'b1;
      watch_lat1 = 1'b1;
      run(2, 60);
      check("hold_redirect_seen", 32'(watch_req || watch_next), 32'd0);

      // Misaligned redirect: fault delivered without any memory request.
      redir_mode = 2;
      redir_tgt  = 32'h8000_0102;
      run(1, 60);
      check("misaligned_no_request", 32'(accepts - acc_at_redir), 32'd0);
      redir_mode = 2;
      redir_tgt  = 32'h8000_0300;
      run(2, 60);

      // Reset while a fetch is outstanding.
      set_env(0, 0, 6, 0);
      for (int i = 0; i < 50 && !mem_busy; i++) cycle();
      check("midrst_in_wait", 32'(bus.imem_rsp_ready), 32'd1);
      reset_n = 1'b0;
      #1;
      check("midrst_rsp_ready", 32'(bus.imem_rsp_ready), 32'd0);
      check("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("midrst_inst_valid", 32'(bus.inst_valid), 32'd0);
      set_env(0, 0, 0, 0);
      @(posedge clock);
      #1;
      do_reset();
      run(2, 40);

      // Random backpressure, errors and redirects against the reference model.
      set_env(1, 3, 3, 3);
      err_en     = 1'b1;
      redir_pct  = 5;
      redir_mode = 3;
      do_reset();
      run(300, 20000);
      redir_mode = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ysyx_25040129_ifu.md
# ysyx_25040129_ifu

Instruction fetch unit for the ysyx_25040129 multi-cycle NPC core. It owns the fetch PC, issues one word-aligned fetch at a time on a valid/ready instruction-memory port, and hands each fetched instruction with its PC to decode on a valid/ready interface. It consumes the redirect produced by branch resolution (`is_branch` / `branch_target`), squashing wrong-path work already in flight.

## Interface
- `RESET_PC`, default 32'h8000_0000: first fetch address after reset.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `redirect_valid`  in  1  redirect request; driven from branch resolution `is_branch`.
- `redirect_target`  in  32  new fetch address; driven from `branch_target`.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  32  fetch address.
- `imem_rsp_valid`  in  1  response valid.
- `imem_rsp_ready`  out  1  IFU accepts the response.
- `imem_rsp_data`  in  32  instruction word.
- `imem_rsp_err`  in  1  access fault for this response.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode accepts the instruction.
- `inst`  out  32  instruction word; 0 when `inst_fault` is 1.
- `inst_pc`  out  32  address of `inst`.
- `inst_fault`  out  1  fetch fault: misaligned address or `imem_rsp_err`.

## Operation
- Registers: `state`, `pc` (next fetch address), `req_addr`, `discard`, `inst`, `inst_pc`, `inst_fault`.
- States: IDLE, FETCH, WAIT, HOLD. Outputs decode from state only:
  - `imem_req_valid = (state==FETCH) && req_addr[1:0]==0`
  - `imem_rsp_ready = (state==WAIT)`
  - `inst_valid = (state==HOLD)`
- Reset: state IDLE, `pc`=`RESET_PC`, `discard`=0, `inst`/`inst_pc`=0, `inst_fault`=0. All valid/ready outputs are 0.
- IDLE -> FETCH, unconditionally. `req_addr <= pc`.
- FETCH, aligned `req_addr`:
  - Hold the request; `imem_req_addr`=`req_addr`, held stable until accepted.
  - On `imem_req_ready`: -> WAIT, `pc <= req_addr+4` (wraps modulo 2^32).
- FETCH, misaligned `req_addr` (`[1:0]!=0`): issue no request; -> HOLD with `inst`=0, `inst_pc`=`req_addr`, `inst_fault`=1.
- WAIT, on `imem_rsp_valid`:
  - If `discard`=1: drop the response, clear `discard`, -> FETCH with `req_addr <= pc`.
  - Otherwise: -> HOLD; latch `inst_pc`=`req_addr`. If `imem_rsp_err`=1, `inst`=0 and `inst_fault`=1; else `inst`=`imem_rsp_data` and `inst_fault`=0.
- HOLD: on `inst_ready` -> FETCH with `req_addr <= pc`.
- Redirect, any state, highest priority:
  - `pc <= redirect_target`, overriding the +4 update in the same cycle.
  - FETCH, request not yet accepted: the request still completes, so protocol stability is kept. Set `discard`.
  - FETCH with request accepted this cycle, or WAIT without a response this cycle: set `discard`.
  - WAIT with a response this cycle, or HOLD: the instruction is squashed and the state goes -> FETCH with `req_addr <= redirect_target`. A HOLD handshake in the same cycle is also squashed; decode is flushed by the same redirect.
  - IDLE: `pc` is overwritten, so the first fetch goes to `redirect_target`.
- Responses while not in WAIT are protocol violations and are ignored.

## Timing
- Minimum 3 cycles per instruction: FETCH (request accepted) -> WAIT (response, at least 1 cycle after acceptance) -> HOLD (handshake). Zero-wait memory plus an always-ready decode gives one instruction per 3 cycles.
- First `imem_req_valid` is asserted in the second cycle after `reset_n` rises. The first cycle is IDLE.
- Redirect latency: the redirected request appears in the cycle after the redirect when in HOLD or in WAIT with a response. Otherwise it appears one cycle after the discarded response is consumed.
- Asserting `reset_n` low mid-transaction clears all state immediately. Memory must abandon the outstanding transaction.
- `inst`, `inst_pc`, `inst_fault` are stable throughout HOLD.

## Test plan
- Reset with `RESET_PC`=8000_0000 and zero-wait memory returning `addr^32'hA5A5_0000`: three instructions delivered with `inst_pc` 8000_0000, 8000_0004, 8000_0008, one per 3 cycles.
- Backpressure: `imem_req_ready` low 4 cycles, response delayed 3 cycles, `inst_ready` low 5 cycles. `imem_req_addr`, `inst` and `inst_pc` stay stable throughout; no instruction is lost or duplicated.
- Redirect to 8000_0100 while in WAIT: the response for the old address is consumed but never reaches decode. The next request address is 8000_0100.
- Redirect in HOLD with `inst_ready`=1 in the same cycle: the next request address is the target. The next delivered `inst_pc` equals the target.
- Redirect to 8000_0102: no memory request is issued. Decode receives `inst_fault`=1, `inst`=0, `inst_pc`=8000_0102.
- `imem_rsp_err`=1 on fetch of 8000_0010: decode receives `inst_fault`=1, `inst`=0. The following fetch is 8000_0014.
